// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Iterative shift-add multiplier with valid/ready handshakes on both sides.
//   Each transaction selects unsigned or two's-complement signed operands.
//   The datapath works on operand magnitudes and fixes up the sign at the end,
//   consuming BITS_PER_CYCLE multiplier bits per CALC cycle. A result therefore
//   takes WIDTH/BITS_PER_CYCLE cycles to compute.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   in_valid     operand pair and mode are valid
//   in_ready     block can accept operands (IDLE only)
//   a            multiplicand, WIDTH bits
//   b            multiplier, WIDTH bits
//   signed_mode  1 = both operands two's complement, 0 = both unsigned
//   out_valid    product is valid (DONE)
//   out_ready    downstream accepts the product
//   product      2*WIDTH-bit result, held until the next result is written
//   busy         high in CALC or DONE
// -----------------------------------------------------------------------------
module seq_multiplier #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int PW    = 2 * WIDTH;
  localparam int PPW   = WIDTH + BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int SH_W  = $clog2(PW);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

  if ((BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) ||
      (WIDTH % BITS_PER_CYCLE != 0)) begin : g_bad_params
    $error("seq_multiplier: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Magnitude of an operand. The most negative value maps onto itself, which
  // is still correct when the result is read as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
    logic [WIDTH-1:0] r;
    if (neg) begin
      r = ~v + WIDTH'(1'b1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Conditional two's-complement negation of the final sum. Negating zero
  // yields zero, so there is no negative zero.
  function automatic logic [PW-1:0] negate_if(input logic [PW-1:0] v,
                                              input logic          neg);
    logic [PW-1:0] r;
    if (neg) begin
      r = ~v + PW'(1'b1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] mcand_q,     mcand_d;
  logic [WIDTH-1:0] mplier_q,    mplier_d;
  logic             sign_q,      sign_d;
  logic [PW-1:0]    acc_q,       acc_d;
  logic [CNT_W-1:0] step_q,      step_d;
  logic [PW-1:0]    product_q,   product_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q,      busy_d;

  logic [PPW-1:0]   pp_s;
  logic [SH_W-1:0]  shamt_s;
  logic [PW-1:0]    sum_s;

  // The multiplier register is shifted right each step, so its low bits are
  // always the next BITS_PER_CYCLE bits to consume.
  assign pp_s    = PPW'(mcand_q) * PPW'(mplier_q[BITS_PER_CYCLE-1:0]);
  assign shamt_s = SH_W'(step_q) * SH_W'(BITS_PER_CYCLE);
  assign sum_s   = acc_q + (PW'(pp_s) << shamt_s);

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = product_q;

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mcand_q     <= {WIDTH{1'b0}};
      mplier_q    <= {WIDTH{1'b0}};
      sign_q      <= 1'b0;
      acc_q       <= {PW{1'b0}};
      step_q      <= {CNT_W{1'b0}};
      product_q   <= {PW{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      sign_q      <= sign_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, datapath update and registered-output decode.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    sign_d    = sign_q;
    acc_d     = acc_q;
    step_d    = step_q;
    product_d = product_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          mcand_d  = magnitude(a, signed_mode & a[WIDTH-1]);
          mplier_d = magnitude(b, signed_mode & b[WIDTH-1]);
          sign_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = {PW{1'b0}};
          step_d   = {CNT_W{1'b0}};
          state_d  = S_CALC;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_CALC: begin
        acc_d    = sum_s;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        step_d   = step_q + CNT_W'(1'b1);
        if (step_q == LAST_STEP) begin
          product_d = negate_if(sum_s, sign_q);
          state_d   = S_DONE;
        end else begin
          state_d   = S_CALC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered copies of the decoded next state, so they
    // change together with the state register.
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
//   Two instances share clock and reset: index 0 uses BITS_PER_CYCLE = 1 and
//   index 1 uses BITS_PER_CYCLE = 4. A transaction-level model (accepted pair,
//   acceptance edge, arithmetic product) is checked against the outputs of
//   both instances on every falling edge. Directed tasks additionally pin
//   hand-computed products and latencies.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv  [2];
  logic        ir  [2];
  logic [15:0] av  [2];
  logic [15:0] bv  [2];
  logic        sm  [2];
  logic        ov  [2];
  logic        ord [2];
  logic [31:0] pr  [2];
  logic        bz  [2];

  seq_multiplier #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut_b1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]), .b(bv[0]),
    .signed_mode(sm[0]), .out_valid(ov[0]), .out_ready(ord[0]), .product(pr[0]), .busy(bz[0])
  );

  seq_multiplier #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut_b4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]), .b(bv[1]),
    .signed_mode(sm[1]), .out_valid(ov[1]), .out_ready(ord[1]), .product(pr[1]), .busy(bz[1])
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ec    = 0;

  // Rising-edge counter used to time the model.
  always @(posedge clk) ec <= ec + 1;

  // Model state per instance.
  logic        pend     [2];
  logic        post_rst [2];
  int          acc_edge [2];
  logic [31:0] expv     [2];
  int          n_acc    [2];
  int          n_hs     [2];

  function automatic int nsteps(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic s);
    longint p;
    if (s) p = longint'($signed(x)) * longint'($signed(y));
    else   p = longint'(x) * longint'(y);
    return p[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle compare against the transaction model.
  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; post_rst[i] = 1'b1; acc_edge[i] = 0;
      expv[i] = 32'd0; n_acc[i] = 0; n_hs[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          check("rst_in_ready",  32'(ir[i]), 32'd0);
          check("rst_out_valid", 32'(ov[i]), 32'd0);
          check("rst_busy",      32'(bz[i]), 32'd0);
          check("rst_product",   pr[i],      32'd0);
          if (pend[i]) n_acc[i]--;
          pend[i]     = 1'b0;
          post_rst[i] = 1'b1;
        end else begin
          logic e_ov, e_ir;
          e_ov = pend[i] && (ec >= acc_edge[i] + nsteps(i));
          e_ir = !pend[i] && !post_rst[i];
          check("mdl_in_ready",  32'(ir[i]), 32'(e_ir));
          check("mdl_out_valid", 32'(ov[i]), 32'(e_ov));
          check("mdl_busy",      32'(bz[i]), 32'(pend[i]));
          if (e_ov) check("mdl_product", pr[i], expv[i]);
          if (ov[i] && ord[i]) n_hs[i]++;
          if (iv[i] && e_ir) begin
            pend[i]     = 1'b1;
            acc_edge[i] = ec + 1;
            expv[i]     = model(av[i], bv[i], sm[i]);
            n_acc[i]++;
          end else if (e_ov && ord[i]) begin
            pend[i] = 1'b0;
          end
          post_rst[i] = 1'b0;
        end
      end
    end
  end

  // Present a pair and return #1 after the edge that accepts it.
  task automatic accept(input int i, input logic [15:0] x, input logic [15:0] y,
                        input logic s);
    int t;
    t = 0;
    while (!ir[i] && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("accept_ready", 32'(ir[i]), 32'd1);
    iv[i] = 1'b1; av[i] = x; bv[i] = y; sm[i] = s;
    @(posedge clk); #1;
    iv[i] = 1'b0;
  endtask

  // Wait for the result, check latency/product, optionally stall, then drain.
  task automatic finish_txn(input int i, input logic [31:0] req, input int lat,
                            input int hold, input string tag);
    int n;
    n = 0;
    ord[i] = (hold == 0);
    while (!ov[i] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_product"}, pr[i], req);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_stall_valid"},   32'(ov[i]), 32'd1);
      check({tag, "_stall_product"}, pr[i],      req);
      check({tag, "_stall_ready"},   32'(ir[i]), 32'd0);
    end
    ord[i] = 1'b1;
    @(posedge clk); #1;
    check({tag, "_drain_valid"}, 32'(ov[i]), 32'd0);
    check({tag, "_drain_ready"}, 32'(ir[i]), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] x, y;
    logic        s;
    int          t;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ord[i] = 1'b1; av[i] = 16'd0; bv[i] = 16'd0; sm[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("ready_low_at_release", 32'(ir[0]), 32'd0);
    @(posedge clk); #1;
    check("ready_after_reset", 32'(ir[0]), 32'd1);

    // Directed products on the one-bit-per-cycle instance.
    accept(0, 16'hFFFF, 16'hFFFF, 1'b0); finish_txn(0, 32'hFFFE0001, 16, 0, "u_ffff");
    accept(0, 16'hFFFD, 16'h0005, 1'b1); finish_txn(0, 32'hFFFFFFF1, 16, 0, "s_m3x5");
    accept(0, 16'hFFFF, 16'hFFFF, 1'b1); finish_txn(0, 32'h00000001, 16, 0, "s_m1xm1");
    accept(0, 16'h8000, 16'h8000, 1'b1); finish_txn(0, 32'h40000000, 16, 0, "s_min_min");
    accept(0, 16'h8000, 16'h0001, 1'b1); finish_txn(0, 32'hFFFF8000, 16, 0, "s_min_one");
    accept(0, 16'd100,  16'd50,   1'b0); finish_txn(0, 32'h00001388, 16, 5, "bp_100x50");

    // Reset in the middle of a calculation.
    accept(0, 16'h1234, 16'h5678, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(ov[0]), 32'd0);
    check("abort_in_ready",  32'(ir[0]), 32'd0);
    check("abort_busy",      32'(bz[0]), 32'd0);
    check("abort_product",   pr[0],      32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("abort_ready_back", 32'(ir[0]), 32'd1);
    t = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (ov[0]) t++;
    end
    check("abort_no_stale_valid", 32'(t), 32'd0);
    accept(0, 16'd5, 16'd10, 1'b0); finish_txn(0, 32'h00000032, 16, 0, "after_abort");

    // Four-bits-per-cycle instance: zero operand still runs full length.
    accept(1, 16'hABCD, 16'h0000, 1'b0); finish_txn(1, 32'h00000000, 4, 0, "b4_zero_u");
    accept(1, 16'hABCD, 16'h0000, 1'b1); finish_txn(1, 32'h00000000, 4, 0, "b4_zero_s");
    accept(1, 16'hFFFD, 16'h0005, 1'b1); finish_txn(1, 32'hFFFFFFF1, 4, 0, "b4_m3x5");

    // Random sweep on the four-bits-per-cycle instance.
    for (int k = 0; k < 200; k++) begin
      x = 16'($urandom);
      y = 16'($urandom_range(0, 65535));
      s = k[0];
      if (k == 0) begin x = 16'h8000; y = 16'hFFFF; end
      if (k == 1) begin x = 16'h7FFF; y = 16'h8000; end
      accept(1, x, y, s);
      finish_txn(1, model(x, y, s), 4, 0, "sweep");
    end

    // in_valid held high with operands changing every cycle, random backpressure.
    for (int c = 0; c < 120; c++) begin
      iv[0]  = 1'b1;
      av[0]  = 16'($urandom);
      bv[0]  = 16'($urandom);
      sm[0]  = 1'($urandom_range(0, 1));
      ord[0] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    iv[0]  = 1'b0;
    ord[0] = 1'b1;
    t = 0;
    while (pend[0] && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("proto_drained", 32'(pend[0]), 32'd0);
    check("proto_accepted_some", 32'(n_acc[0] > 10), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("handshakes_b1", 32'(n_hs[0]), 32'(n_acc[0]));
    check("handshakes_b4", 32'(n_hs[1]), 32'(n_acc[1]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised, iterative shift-add multiplier with valid/ready handshakes on both the input and output sides. It supports unsigned and two's-complement signed operands, selected per transaction. Throughput and latency are set by BITS_PER_CYCLE. It is the area-lean, clocked successor to the combinational 16-bit array and Wallace multipliers, for datapaths that can tolerate multi-cycle latency.

Parameters:
WIDTH, 16, operand width in bits; product is 2*WIDTH bits.
BITS_PER_CYCLE, 1, multiplier bits consumed per CALC cycle; legal values 1, 2, 4; must divide WIDTH (elaboration-time check, $error otherwise).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand pair and mode valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
signed_mode  input  1  1 = both operands two's complement; 0 = both unsigned.
out_valid  output  1  product valid.
out_ready  input  1  downstream accepts product.
product  output  2*WIDTH  result.
busy  output  1  high in CALC or DONE.

Behaviour:
- Reset: clk and rst are as described above (one clock; rst asynchronous, active-high). While rst is high: state = IDLE, in_ready = 0, out_valid = 0, busy = 0, product = 0, accumulator and counter cleared. in_ready rises in the first cycle after rst deasserts.
- Let N = WIDTH/BITS_PER_CYCLE.
- States: IDLE, CALC, DONE.
- IDLE: in_ready = 1, busy = 0.
  - On an edge where in_valid && in_ready: latch |a|, |b| (magnitudes if signed_mode, else raw values), latch sign = signed_mode & (a[MSB] ^ b[MSB]), clear the accumulator, set the step counter to 0, and go to CALC.
  - a, b and signed_mode are sampled only at acceptance.
- CALC: in_ready = 0.
  - Each cycle: acc += (mcand * next BITS_PER_CYCLE LSBs of mplier) << (step*BITS_PER_CYCLE); step++.
  - Use an unsigned WIDTH x BITS_PER_CYCLE partial product. The accumulator is 2*WIDTH bits and never overflows.
  - On the step where step == N-1, the final sum is registered into product (two's-complement negated if sign = 1), and the state moves to DONE.
- DONE: out_valid = 1 and product is stable.
  - On an edge where out_valid && out_ready, go to IDLE and drop out_valid.
  - in_ready stays 0 in DONE, so there is no overlap of transactions.
- Latency:
  - Acceptance at edge k gives out_valid = 1 after edge k+N (N = 16 for the defaults).
  - With out_ready held high, the next in_ready = 1 comes after edge k+N+1.
  - Minimum initiation interval is N+2 cycles.
- Magnitude: the most negative operand (0x8000 at WIDTH = 16) has magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits. The signed product range always fits in 2*WIDTH bits.
- Zero operand: a full N-cycle computation still runs (no early termination), and the result is 0 with no negative zero.
- product holds its last value after the output handshake until the next result is written. It is only meaningful while out_valid = 1.
- in_valid asserted during CALC or DONE is ignored (not latched). The upstream must hold it until in_ready.
- Reset mid-operation, in any state: immediate abort with all outputs at reset values. No stale product is later presented.
- out_ready held low in DONE: the block stalls indefinitely, with product and out_valid stable.

Test Plan:
- Unsigned 0xFFFF x 0xFFFF (signed_mode = 0, WIDTH = 16, BITS_PER_CYCLE = 1) -> product 0xFFFE0001; out_valid exactly 16 edges after acceptance.
- Signed cases:
  - -3 x 5 (0xFFFD, 0x0005) -> 0xFFFFFFF1.
  - -1 x -1 -> 0x00000001.
  - 0x8000 x 0x8000 -> 0x40000000.
  - 0x8000 x 0x0001 -> 0xFFFF8000.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE on 100 x 50 -> product stays 0x00001388, out_valid = 1, and in_ready = 0 throughout. It completes on the first out_ready = 1 edge.
- Reset at CALC step 7 of 0x1234 x 0x5678 -> all outputs 0 immediately. After release: no out_valid, in_ready = 1; a new transaction 5 x 10 -> 0x00000032.
- Instance with BITS_PER_CYCLE = 4: 0xABCD x 0x0000 -> 0 after 4 cycles. A random sweep of 200 unsigned and signed pairs is compared against a behavioural model (a*b, or $signed(a)*$signed(b)), with zero mismatches.
- Protocol: hold in_valid high continuously with changing operands -> only values present at in_ready edges are multiplied, and each accepted pair yields exactly one out_valid handshake.
